// File: rtl/iobs_pwq.sv
// iobs_pwq: FSB-side I/O bridge controller with a DEPTH-entry posted-write queue.
// Queued writes are issued in order, then non-posted cycles; posted errors go to PWERR.
// Ports:
//   CLK, nRST                  clock, synchronous active-low reset
//   nWE nAS nLDS nUDS          68000 strobes
//   BACT BACTr                 bus cycle active, and delayed one cycle
//   IOCS IORealCS IOPWCS       I/O selects (posted-write capable on IOPWCS)
//   IOACT IODONEin IOBERR      asynchronous IOB master status
//   PWERR_CLR                  clears the sticky posted-write error
//   IONPReady IOPWReady        non-posted / posted cycle termination
//   nBERR_FSB nDinOE           FSB bus error, read data output enable
//   IOREQ IORW ALE0 IOL0 IOU0  request bundle to the IOB master
//   LE SEL SELFSB              slot latch strobes and issue mux select
//   QCOUNT PWERR               queue occupancy, sticky posted-write error
module iobs_pwq #(
  parameter int DEPTH = 2,
  parameter int SYNC_STAGES = 1,
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            nWE,
  input  logic            nAS,
  input  logic            nLDS,
  input  logic            nUDS,
  input  logic            BACT,
  input  logic            BACTr,
  input  logic            IOCS,
  input  logic            IORealCS,
  input  logic            IOPWCS,
  input  logic            IOACT,
  input  logic            IODONEin,
  input  logic            IOBERR,
  input  logic            PWERR_CLR,
  output logic            IONPReady,
  output logic            IOPWReady,
  output logic            nBERR_FSB,
  output logic            nDinOE,
  output logic            IOREQ,
  output logic            IORW,
  output logic            ALE0,
  output logic            IOL0,
  output logic            IOU0,
  output logic [DEPTH-1:0] LE,
  output logic [PTRW-1:0] SEL,
  output logic            SELFSB,
  output logic [PTRW:0]   QCOUNT,
  output logic            PWERR
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAITACT,
    WAITDONE
  } state_t;

  localparam logic [PTRW:0]   QMAX  = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] PLAST = PTRW'(DEPTH-1);

  state_t state;

  logic [SYNC_STAGES-1:0] act_q;
  logic [SYNC_STAGES-1:0] done_q;
  logic [SYNC_STAGES-1:0] berr_q;

  logic act_s;
  logic done_s;
  logic berr_s;

  logic [DEPTH-1:0] lo_q;
  logic [DEPTH-1:0] up_q;
  logic [PTRW-1:0]  wptr;
  logic [PTRW-1:0]  rptr;

  logic sent;
  logic np;
  logic posted;
  logic new_cyc;
  logic enq;
  logic pop;
  logic np_acc;

  assign act_s  = act_q[SYNC_STAGES-1];
  assign done_s = done_q[SYNC_STAGES-1];
  assign berr_s = berr_q[SYNC_STAGES-1];

  assign posted  = IOPWCS && !nWE;
  assign new_cyc = BACT && IOCS && !sent;
  assign enq     = new_cyc && posted && (QCOUNT < QMAX);
  assign np_acc  = new_cyc && !posted &&
                   (QCOUNT == '0) && (state == IDLE);
  assign pop     = (state == WAITDONE) && !act_s && !SELFSB;

  assign IOPWReady = sent;
  assign nDinOE    = !(!nAS && BACTr && IORealCS && nWE);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      act_q  <= '0;
      done_q <= '0;
      berr_q <= '0;
    end else begin
      act_q[0]  <= IOACT;
      done_q[0] <= IODONEin;
      berr_q[0] <= IOBERR;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        act_q[i]  <= act_q[i-1];
        done_q[i] <= done_q[i-1];
        berr_q[i] <= berr_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      lo_q   <= '0;
      up_q   <= '0;
      wptr   <= '0;
      rptr   <= '0;
      LE     <= '0;
      QCOUNT <= '0;
    end else begin
      LE <= '0;
      if (enq) begin
        lo_q[wptr] <= !nLDS;
        up_q[wptr] <= !nUDS;
        LE         <= DEPTH'(1) << wptr;
        wptr       <= (wptr == PLAST) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == PLAST) ? '0 : rptr + 1'b1;
      end
      case ({enq, pop})
        2'b10:   QCOUNT <= QCOUNT + 1'b1;
        2'b01:   QCOUNT <= QCOUNT - 1'b1;
        default: QCOUNT <= QCOUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      IOREQ  <= 1'b0;
      ALE0   <= 1'b0;
      IORW   <= 1'b1;
      IOL0   <= 1'b0;
      IOU0   <= 1'b0;
      SEL    <= '0;
      SELFSB <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          IOREQ <= 1'b0;
          ALE0  <= 1'b0;
          if (QCOUNT != '0) begin
            SELFSB <= 1'b0;
            SEL    <= rptr;
            IORW   <= 1'b0;
            IOL0   <= lo_q[rptr];
            IOU0   <= up_q[rptr];
            state  <= START;
          end else if (np_acc) begin
            SELFSB <= 1'b1;
            IORW   <= nWE;
            IOL0   <= !nLDS;
            IOU0   <= !nUDS;
            state  <= START;
          end
        end
        START: begin
          IOREQ <= 1'b1;
          ALE0  <= 1'b1;
          // FSB strobes may settle late in the cycle; take them again.
          if (SELFSB) begin
            IOL0 <= !nLDS;
            IOU0 <= !nUDS;
          end
          state <= WAITACT;
        end
        WAITACT: begin
          if (act_s) begin
            IOREQ <= 1'b0;
            state <= WAITDONE;
          end
        end
        WAITDONE: begin
          ALE0 <= 1'b0;
          if (!act_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sent      <= 1'b0;
      np        <= 1'b0;
      IONPReady <= 1'b0;
      nBERR_FSB <= 1'b1;
    end else if (!BACT) begin
      sent      <= 1'b0;
      np        <= 1'b0;
      IONPReady <= 1'b0;
      nBERR_FSB <= 1'b1;
    end else begin
      if (enq || np_acc) begin
        sent <= 1'b1;
      end
      if (np_acc) begin
        np <= 1'b1;
      end
      if (sent && np && done_s) begin
        IONPReady <= 1'b1;
      end
      if (sent && np && berr_s) begin
        nBERR_FSB <= 1'b0;
      end
    end
  end

  // The FSB cycle of a posted write is long gone, so its error is kept here.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      PWERR <= 1'b0;
    end else if (berr_s && (state != IDLE) && !SELFSB) begin
      PWERR <= 1'b1;
    end else if (PWERR_CLR) begin
      PWERR <= 1'b0;
    end
  end

endmodule
